// File: rtl/fp_add_normalize.sv
// Mantissa add/subtract and iterative normalization stage of the single-precision adder.
// Takes aligned extended mantissas plus the larger operand's sign and exponent.
// Returns a packed Float32 through a valid/ready handshake.
// Normalization shifts left by one bit per cycle. Rounding is truncation only.
// Denormal results are flushed to +0.
//
// state | meaning
// IDLE  | waiting for an operand bundle, in_ready high
// NORM  | left-shifting m / decrementing e until m[23] is set or e bottoms out
// DONE  | result held, out_valid high until downstream accepts
module fp_add_normalize (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        gt_sign,
  input  logic        lt_sign,
  input  logic [7:0]  gt_exp,
  input  logic [23:0] gt_m_ext,
  input  logic [23:0] lt_m_ext,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] m_q, m_d;
  logic [7:0]  e_q, e_d;
  logic        s_q, s_d;
  logic [31:0] result_q, result_d;

  logic [24:0] sum;
  logic [8:0]  exp_inc;

  // Upstream guarantees gt_m_ext >= lt_m_ext, so the subtraction never goes negative.
  // exp_inc is 9 bits wide so that the carry-out case can see 255 without wrapping.
  always_comb begin
    if (gt_sign == lt_sign) sum = {1'b0, gt_m_ext} + {1'b0, lt_m_ext};
    else                    sum = {1'b0, gt_m_ext} - {1'b0, lt_m_ext};
    exp_inc = {1'b0, gt_exp} + 9'd1;
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      m_q      <= '0;
      e_q      <= '0;
      s_q      <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      e_q      <= e_d;
      s_q      <= s_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath update: one normalization step per cycle while in NORM.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    e_d      = e_q;
    s_d      = s_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d = gt_sign;
          if (gt_exp == 8'hFF) begin
            result_d = {gt_sign, 8'hFF, 23'd0};
            state_d  = DONE;
          end else if (sum == 25'd0) begin
            // Exact cancellation always yields +0.
            result_d = 32'h0000_0000;
            state_d  = DONE;
          end else if (sum[24]) begin
            m_d = sum[24:1];
            e_d = exp_inc[7:0];
            if (exp_inc == 9'd255) begin
              result_d = {gt_sign, 8'hFF, 23'd0};
              state_d  = DONE;
            end else begin
              state_d = NORM;
            end
          end else begin
            m_d     = sum[23:0];
            e_d     = gt_exp;
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (m_q[23]) begin
          result_d = {s_q, e_q, m_q[22:0]};
          state_d  = DONE;
        end else if (e_q <= 8'd1) begin
          result_d = 32'h0000_0000;
          state_d  = DONE;
        end else begin
          m_d = {m_q[22:0], 1'b0};
          e_d = e_q - 8'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_fp_add_normalize.sv
// Self-checking bench for fp_add_normalize.
// Table-driven vectors are applied through a scoreboard queue.
// Hand-written sequences cover backpressure and reset during normalization.
module tb_fp_add_normalize;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        gt_sign;
  logic        lt_sign;
  logic [7:0]  gt_exp;
  logic [23:0] gt_m_ext;
  logic [23:0] lt_m_ext;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  fp_add_normalize dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gt_sign   (gt_sign),
    .lt_sign   (lt_sign),
    .gt_exp    (gt_exp),
    .gt_m_ext  (gt_m_ext),
    .lt_m_ext  (lt_m_ext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        gs;
    logic        ls;
    logic [7:0]  ge;
    logic [23:0] gm;
    logic [23:0] lm;
    logic [31:0] res;
    int          lat;   // index of the edge after which out_valid is high (accept = edge 0)
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    gt_sign  = v.gs;
    lt_sign  = v.ls;
    gt_exp   = v.ge;
    gt_m_ext = v.gm;
    lt_m_ext = v.lm;
    in_valid = 1'b1;
  endtask

  // Waits (bounded) for out_valid. Returns the edge index after which it rose, or -1.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic run_op(input vec_t v);
    int   lat;
    exp_t e;
    @(negedge clk);
    chk({v.name, "_in_ready_before"}, {31'd0, in_ready}, 32'd1);
    drive(v);
    sb.push_back('{v.res, v.lat});
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    e = sb.pop_front();
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: out_valid never rose, expected after edge %0d", v.name, e.lat);
    end else begin
      chk({v.name, "_result"}, result, e.res);
      chk({v.name, "_latency"}, lat, e.lat);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({v.name, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
      chk({v.name, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    int   lat;
    exp_t e;
    vec_t bp;
    vec_t other;
    vec_t deep;

    vecs.push_back('{"one_plus_one",  1'b0, 1'b0, 8'd127, 24'h800000, 24'h800000, 32'h4000_0000, 1});
    vecs.push_back('{"one_minus_075", 1'b0, 1'b1, 8'd127, 24'h800000, 24'h600000, 32'h3E80_0000, 3});
    vecs.push_back('{"cancel",        1'b0, 1'b1, 8'd127, 24'h800000, 24'h800000, 32'h0000_0000, 0});
    vecs.push_back('{"cancel_neg",    1'b1, 1'b0, 8'd90,  24'hABCDEF, 24'hABCDEF, 32'h0000_0000, 0});
    vecs.push_back('{"overflow",      1'b0, 1'b0, 8'd254, 24'hFFFFFF, 24'hFFFFFF, 32'h7F80_0000, 0});
    vecs.push_back('{"inf_pos",       1'b0, 1'b1, 8'd255, 24'h912345, 24'h000777, 32'h7F80_0000, 0});
    vecs.push_back('{"inf_neg",       1'b1, 1'b1, 8'd255, 24'h800000, 24'h400000, 32'hFF80_0000, 0});
    vecs.push_back('{"flush",         1'b0, 1'b1, 8'd2,   24'h800000, 24'h7FFFFF, 32'h0000_0000, 2});
    vecs.push_back('{"flush_e1",      1'b0, 1'b1, 8'd1,   24'h800000, 24'h400000, 32'h0000_0000, 1});
    vecs.push_back('{"carry_e101",    1'b0, 1'b0, 8'd100, 24'hC00000, 24'h400000, 32'h3280_0000, 1});
    vecs.push_back('{"neg_no_shift",  1'b1, 1'b1, 8'd127, 24'h800000, 24'h400000, 32'hBFC0_0000, 1});
    vecs.push_back('{"neg_sub",       1'b1, 1'b0, 8'd130, 24'hC00000, 24'h400000, 32'hC100_0000, 1});
    vecs.push_back('{"truncate",      1'b0, 1'b0, 8'd127, 24'hFFFFFF, 24'h000002, 32'h4000_0000, 1});
    vecs.push_back('{"deep_shift",    1'b0, 1'b1, 8'd127, 24'h800000, 24'h7FFFFF, 32'h3400_0000, 24});

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    gt_sign   = 1'b0;
    lt_sign   = 1'b0;
    gt_exp    = '0;
    gt_m_ext  = '0;
    lt_m_ext  = '0;
    #12;
    chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result",    result,             32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Backpressure: hold out_ready low and offer a competing bundle that must be ignored.
    bp    = vecs[0];
    other = vecs[2];
    @(negedge clk);
    drive(bp);
    sb.push_back('{bp.res, bp.lat});
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    e = sb.pop_front();
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL bp_timeout: out_valid never rose, expected after edge %0d", e.lat);
    end else begin
      chk("bp_result", result, e.res);
      drive(other);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk("bp_hold_result",    result,             e.res);
        chk("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_in_ready",  {31'd0, in_ready},  32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
      chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    end

    // Reset asserted while normalizing aborts the operation with no output.
    deep = vecs[vecs.size() - 1];
    @(negedge clk);
    drive(deep);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("norm_busy_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_result",    result,             32'h0);
    chk("rst_mid_in_ready",  {31'd0, in_ready},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_after_out_valid", {31'd0, out_valid}, 32'd0);
    end

    run_op(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
